// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
// Holds the fetch FSM state encoding, word widths, the halt opcode and the
// queue entry layout used by fetch_ctrl and fetch_buf.
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  // An all-zero instruction word stops the fetch stream.
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  // One queued fetch result: the byte address it came from and the word itself.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: two-entry synchronous FIFO of fetch_entry_t feeding decode.
// Slot e0 is always the head, so the head outputs come straight from a
// register. A push and a pop in the same cycle are accepted even when full.
// Flush empties the queue and overrides any push or pop in that cycle.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

  fetch_entry_t e0;
  fetch_entry_t e1;
  logic [1:0]   cnt;

  // Queue storage and occupancy; entries shift toward e0 on every pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            e0 <= din;
          end else begin
            e1 <= din;
          end
          if (cnt != FULL_CNT) begin
            cnt <= cnt + 2'd1;
          end
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind the survivor.
          if (cnt == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head  = e0;
  assign count = cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the 16-bit core.
// Owns the program counter, addresses a combinational 16-word ROM, and queues
// fetched words (with their PCs) toward decode through fetch_buf using a
// valid/ready handshake. Redirects reload the PC and flush the queue; the
// all-zero halt word stops fetch while the queue keeps draining.
// Optional build macro FETCH_ADDR_CHECK_EN: when defined, a PC at or beyond
// IMEM_BYTES stops fetch in the FAULT state and raises fault_o; otherwise
// fault_o is tied low and an out-of-range PC simply reads the halt word.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          IMEM_BYTES = 32,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_pc_o,
  input  logic [INSTR_W-1:0] imem_instr_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [PC_W-1:0]    out_pc_o,
  output logic               halted_o,
  output logic               fault_o
);

  localparam logic [1:0]  FULL_CNT   = 2'(BUF_DEPTH);
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

  fetch_state_e    state;
  logic [PC_W-1:0] pc_q;
  logic            halted_q;

  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic [1:0]      count;

  logic            pop;
  logic            push_ok;
  logic            is_halt_word;
  logic            addr_bad;
  logic            push;

  // Bit 0 of the redirect target is discarded and IMEM_LIMIT is only needed
  // by the optional address check; fold them here so both builds see them used.
  logic            unused_bits;
  assign unused_bits = ^{redirect_pc_i[0], IMEM_LIMIT[0]};

  // Handshake and fetch decisions for the current cycle.
  always_comb begin
    pop          = out_valid_o & out_ready_i & ~redirect_i;
    push_ok      = (count != FULL_CNT) | pop;
    is_halt_word = (imem_instr_i == HALT_WORD);
`ifdef FETCH_ADDR_CHECK_EN
    addr_bad     = ({16'b0, pc_q} >= IMEM_LIMIT);
`else
    addr_bad     = 1'b0;
`endif
    push         = (state == RUN) & ~redirect_i & ~addr_bad & push_ok & ~is_halt_word;
    push_entry.pc    = pc_q;
    push_entry.instr = imem_instr_i;
  end

  // Fetch FSM: redirect beats everything except reset; RUN advances the PC on
  // every accepted push and parks on the halt word without queueing it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else if (redirect_i) begin
      state    <= RUN;
      pc_q     <= {redirect_pc_i[PC_W-1:1], 1'b0};
      halted_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (addr_bad) begin
            state <= FAULT;
          end else if (push_ok) begin
            if (is_halt_word) begin
              state    <= HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + 16'd2;
            end
          end
        end
        HALT: begin
          halted_q <= 1'b1;
        end
        FAULT: begin
          halted_q <= 1'b0;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef FETCH_ADDR_CHECK_EN
  logic fault_q;

  // Address-fault flag: set when RUN sees an out-of-range PC, cleared only by
  // redirect or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect_i) begin
      fault_q <= 1'b0;
    end else if ((state == RUN) && addr_bad) begin
      fault_q <= 1'b1;
    end
  end

  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

  fetch_buf #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_i),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign imem_pc_o   = pc_q;
  assign out_valid_o = (count != 2'd0);
  assign out_instr_o = head.instr;
  assign out_pc_o    = head.pc;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a small behavioural ROM.
// Build with FETCH_ADDR_CHECK_EN defined to exercise the address-fault path.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_pc;
  logic [15:0] imem_instr;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_word [0:5] = '{16'h8180, 16'h2CB2, 16'hDC67, 16'hDDD9, 16'hFDB1, 16'hC07B};

  fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_pc_o     (imem_pc),
    .imem_instr_i  (imem_instr),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_instr_o   (out_instr),
    .out_pc_o      (out_pc),
    .halted_o      (halted),
    .fault_o       (fault)
  );

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    if (a >= 16'd32) return 16'h0000;
    case (a[4:1])
      4'd0: return 16'h8180;
      4'd1: return 16'h2CB2;
      4'd2: return 16'hDC67;
      4'd3: return 16'hDDD9;
      4'd4: return 16'hFDB1;
      4'd5: return 16'hC07B;
      4'd6: return 16'h0000;
      default: return 16'hA5A5;
    endcase
  endfunction

  always_comb imem_instr = rom_word(imem_pc);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    out_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;

    // Reset state
    tick();
    tick();
    chk("rst_valid",  {15'b0, out_valid}, 16'd0);
    chk("rst_instr",  out_instr, 16'h0000);
    chk("rst_pc",     out_pc, 16'h0000);
    chk("rst_halted", {15'b0, halted}, 16'd0);
    chk("rst_fault",  {15'b0, fault}, 16'd0);
    chk("rst_imem",   imem_pc, 16'h0000);

    // Sequential run up to the halt word
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("seq_valid", {15'b0, out_valid}, 16'd1);
      chk("seq_pc",    out_pc, 16'(2 * i));
      chk("seq_instr", out_instr, exp_word[i]);
    end
    tick();
    chk("halt_valid",  {15'b0, out_valid}, 16'd0);
    chk("halt_flag",   {15'b0, halted}, 16'd1);
    chk("halt_imem",   imem_pc, 16'd12);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_hold_valid", {15'b0, out_valid}, 16'd0);
      chk("halt_hold_imem",  imem_pc, 16'd12);
      chk("halt_hold_flag",  {15'b0, halted}, 16'd1);
    end

    // Redirect out of HALT
    redirect    = 1'b1;
    redirect_pc = 16'h0002;
    tick();
    redirect = 1'b0;
    chk("rdh_halted", {15'b0, halted}, 16'd0);
    chk("rdh_valid",  {15'b0, out_valid}, 16'd0);
    chk("rdh_imem",   imem_pc, 16'h0002);
    tick();
    chk("rdh_valid2", {15'b0, out_valid}, 16'd1);
    chk("rdh_pc",     out_pc, 16'h0002);
    chk("rdh_instr",  out_instr, 16'h2CB2);

    // Backpressure from reset
    rst_n     = 1'b0;
    out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("bp_valid1", {15'b0, out_valid}, 16'd1);
    chk("bp_pc1",    out_pc, 16'h0000);
    tick();
    chk("bp_imem_full", imem_pc, 16'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", {15'b0, out_valid}, 16'd1);
      chk("bp_hold_pc",    out_pc, 16'h0000);
      chk("bp_hold_instr", out_instr, 16'h8180);
      chk("bp_hold_imem",  imem_pc, 16'd4);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      tick();
      chk("bp_drain_valid", {15'b0, out_valid}, 16'd1);
      chk("bp_drain_pc",    out_pc, 16'(2 * i));
      chk("bp_drain_instr", out_instr, exp_word[i]);
    end
    tick();
    chk("bp_end_valid",  {15'b0, out_valid}, 16'd0);
    chk("bp_end_halted", {15'b0, halted}, 16'd1);

    // Redirect with a full queue
    out_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0000;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    chk("rdf_pre_imem", imem_pc, 16'd4);
    redirect    = 1'b1;
    redirect_pc = 16'h0004;
    out_ready   = 1'b1;
    tick();
    redirect  = 1'b0;
    out_ready = 1'b0;
    chk("rdf_valid0", {15'b0, out_valid}, 16'd0);
    chk("rdf_imem",   imem_pc, 16'd4);
    tick();
    chk("rdf_valid1", {15'b0, out_valid}, 16'd1);
    chk("rdf_pc",     out_pc, 16'h0004);
    chk("rdf_instr",  out_instr, 16'hDC67);
    out_ready = 1'b1;
    tick();
    chk("rdf_next_pc",    out_pc, 16'h0006);
    chk("rdf_next_instr", out_instr, 16'hDDD9);

    // Odd redirect target
    redirect    = 1'b1;
    redirect_pc = 16'h0007;
    tick();
    redirect = 1'b0;
    chk("odd_imem",  imem_pc, 16'h0006);
    chk("odd_valid0", {15'b0, out_valid}, 16'd0);
    tick();
    chk("odd_pc",    out_pc, 16'h0006);
    chk("odd_instr", out_instr, 16'hDDD9);

    // Out-of-range redirect target
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("oor_imem", imem_pc, 16'h0040);
    tick();
    chk("oor_valid", {15'b0, out_valid}, 16'd0);
`ifdef FETCH_ADDR_CHECK_EN
    chk("oor_fault",  {15'b0, fault}, 16'd1);
    chk("oor_halted", {15'b0, halted}, 16'd0);
`else
    chk("oor_halted", {15'b0, halted}, 16'd1);
    chk("oor_fault",  {15'b0, fault}, 16'd0);
`endif

    // Reset with a full queue and a pending redirect
    out_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0000;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    chk("rsf_pre_valid", {15'b0, out_valid}, 16'd1);
    chk("rsf_pre_imem",  imem_pc, 16'd4);
    rst_n       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    chk("rsf_valid",  {15'b0, out_valid}, 16'd0);
    chk("rsf_imem",   imem_pc, 16'h0000);
    chk("rsf_halted", {15'b0, halted}, 16'd0);
    chk("rsf_fault",  {15'b0, fault}, 16'd0);
    rst_n    = 1'b1;
    redirect = 1'b0;
    tick();
    chk("rsf_first_valid", {15'b0, out_valid}, 16'd1);
    chk("rsf_first_pc",    out_pc, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
